ir_cmd_ctrl: RTL and testbench

Controller that sequences the NEC infrared decoder and turns its raw 32-bit frames into validated key events. Drives the decoder's `enable`/`ack` handshake, checks the NEC complement bytes, drops illegal frames, and buffers good keys in a small FIFO for the CPU/peripheral side. Sits between the IR decoder and the system register bus.

---
 rtl/ir_pkg.sv | 12 +
 rtl/ir_key_fifo.sv | 36 +++
 rtl/ir_cmd_ctrl.sv | 95 +++++++++
 tb/tb_ir_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared FSM states, NEC frame layout and frame validity check for the IR command controller
package ir_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, PUSH, ACK} state_t;
  localparam int ADDR_LSB = 0;
  localparam int NADDR_LSB = 8;
  localparam int CODE_LSB = 16;
  localparam int NCODE_LSB = 24;
  localparam int KEY_W = 16;
  function automatic logic frame_ok(input logic [31:0] c);
    return (c[CODE_LSB+:8] == ~c[NCODE_LSB+:8]) && (c[ADDR_LSB+:8] == ~c[NADDR_LSB+:8]);
  endfunction
endpackage

// File: rtl/ir_key_fifo.sv
// ir_key_fifo: small synchronous key FIFO with wrap-bit pointers and async reset
module ir_key_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  // pointer advance on accepted push/pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  // storage write; head is masked while empty so no reset is needed here
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: NEC decoder sequencer, frame validation and key FIFO; IR_REPEAT_FILTER_EN adds a repeat-key holdoff filter
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF_CYCLES = 2_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_enable,
  input  logic             dec_ready,
  input  logic [31:0]      dec_command,
  output logic             dec_enable,
  output logic             dec_ack,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_data,
  input  logic             key_pop,
  output logic             fifo_full,
  output logic [7:0]       err_count,
  output logic             ovf,
  input  logic             err_clr
);
  state_t state_q;
  logic [31:0] cmd_q;
  logic dec_enable_q, dec_ack_q, ovf_q, fifo_empty, ok, go_push, repeat_hit;
  logic [7:0] err_q;
  logic [KEY_W-1:0] key;
  assign key = {cmd_q[ADDR_LSB+:8], cmd_q[CODE_LSB+:8]};
  assign ok = frame_ok(cmd_q);
  assign go_push = ok && !fifo_full && !repeat_hit;
  assign dec_enable = dec_enable_q;
  assign dec_ack = dec_ack_q;
  assign key_valid = !fifo_empty;
  assign err_count = err_q;
  assign ovf = ovf_q;

  ir_key_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_W)) u_fifo (
    .clk(clk), .rst(rst), .push(state_q == PUSH), .pop(key_pop), .din(key),
    .dout(key_data), .full(fifo_full), .empty(fifo_empty)
  );

`ifdef IR_REPEAT_FILTER_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] hold_q;
  logic [KEY_W-1:0] last_q;
  logic none_q;
  assign repeat_hit = !none_q && (last_q == key) && (hold_q != '0);
  // remember the last pushed key and count down its holdoff window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_q <= '0;
      last_q <= '0;
      none_q <= 1'b1;
    end else if (state_q == PUSH) begin
      hold_q <= HW'(HOLDOFF_CYCLES);
      last_q <= key;
      none_q <= 1'b0;
    end else if (hold_q != '0) hold_q <= hold_q - 1'b1;
`else
  assign repeat_hit = 1'b0;
`endif

  // frame sequencing with registered handshake outputs and error bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      dec_enable_q <= 1'b0;
      dec_ack_q <= 1'b0;
      err_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dec_enable_q <= sw_enable;
      err_q <= err_clr ? 8'd0 : (state_q == CHECK && !ok && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
      ovf_q <= !err_clr && (ovf_q || (state_q == CHECK && ok && fifo_full));
      case (state_q)
        IDLE: if (dec_ready && dec_enable_q) begin
          cmd_q <= dec_command;
          state_q <= CHECK;
        end
        CHECK: begin
          state_q <= go_push ? PUSH : ACK;
          dec_ack_q <= !go_push;
        end
        PUSH: begin
          state_q <= ACK;
          dec_ack_q <= 1'b1;
        end
        default: if (!dec_ready) begin
          state_q <= IDLE;
          dec_ack_q <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: randomized and directed scoreboard bench for ir_cmd_ctrl (IR_REPEAT_FILTER_EN selects filter model)
module tb_ir_cmd_ctrl;
  localparam int DEPTH = 4;
  localparam int H = 100;
`ifdef IR_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 0, rst = 1, sw_enable = 0, dec_ready = 0, err_clr = 0;
  logic mon_pop = 0, dir_pop = 0, key_pop;
  logic [31:0] dec_command = 0;
  logic dec_enable, dec_ack, key_valid, fifo_full, ovf;
  logic [15:0] key_data;
  logic [7:0] err_count;
  assign key_pop = mon_pop | dir_pop;

  int n_chk = 0, n_fail = 0, mode = 0, cyc = 0, err_exp = 0, last_push = 0;
  bit ovf_exp = 0, none = 1;
  logic [15:0] last_key = 0;
  logic [15:0] exp_q[$];

  ir_cmd_ctrl #(.FIFO_DEPTH(DEPTH), .HOLDOFF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .sw_enable(sw_enable), .dec_ready(dec_ready), .dec_command(dec_command),
    .dec_enable(dec_enable), .dec_ack(dec_ack), .key_valid(key_valid), .key_data(key_data),
    .key_pop(key_pop), .fifo_full(fifo_full), .err_count(err_count), .ovf(ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // monitor: pops the DUT head and compares it with the scoreboard front
  always @(negedge clk) begin
    mon_pop = 0;
    if (!rst && mode != 0 && key_valid) begin
      if (exp_q.size() == 0) check("unexpected_key", {16'h0, key_data}, 32'hFFFF_FFFF);
      else if (mode == 2 || $urandom_range(1) == 1) begin
        check("key_order", key_data, exp_q[0]);
        void'(exp_q.pop_front());
        mon_pop = 1;
      end
    end
  end

  task automatic model_frame(input logic [31:0] f, output bit push);
    logic [15:0] k;
    bit ok;
    k = {f[7:0], f[23:16]};
    ok = (f[23:16] == ~f[31:24]) && (f[7:0] == ~f[15:8]);
    push = 0;
    if (!ok) err_exp = (err_exp == 255) ? 255 : err_exp + 1;
    else if (exp_q.size() >= DEPTH) ovf_exp = 1;
    else if (!(FILT && !none && k == last_key && cyc - last_push < H)) begin
      push = 1;
      exp_q.push_back(k);
      last_key = k;
      none = 0;
      last_push = cyc + 3;
    end
  endtask

  task automatic send(input logic [31:0] f);
    int n;
    bit push;
    model_frame(f, push);
    dec_command = f;
    dec_ready = 1;
    n = 0;
    while (!dec_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", n, push ? 3 : 2);
    if (push) check("key_valid_at_ack", key_valid, 1);
    repeat ($urandom_range(2)) begin
      @(negedge clk);
      check("ack_hold", dec_ack, 1);
    end
    dec_ready = 0;
    @(negedge clk);
    check("ack_drop", dec_ack, 0);
    check("err_count", err_count, err_exp);
    check("ovf", ovf, ovf_exp);
  endtask

  task automatic drain();
    int n;
    mode = 2;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("drain_empty", key_valid, 0);
    mode = 0;
  endtask

  task automatic clear_errs();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    err_exp = 0;
    ovf_exp = 0;
    check("clr_err", err_count, 0);
    check("clr_ovf", ovf, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_dec_enable"}, dec_enable, 0);
    check({tag, "_dec_ack"}, dec_ack, 0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_data"}, key_data, 0);
    check({tag, "_fifo_full"}, fifo_full, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    logic [31:0] f;
    logic [15:0] k;
    bit push;
    int n, t;
    sw_enable = 1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 0;
    @(negedge clk);
    check("dec_enable_on", dec_enable, 1);

    send(32'hF708FB04);
    check("first_key", key_data, 16'h0408);
    drain();

    send(32'hF709FB04);
    repeat (255) send(mk(8'($urandom), 8'($urandom)) ^ (32'd1 << $urandom_range(31)));
    check("err_sat", err_count, 255);
    clear_errs();

    for (int i = 1; i <= 5; i++) begin
      send(mk(8'h10, 8'(i)));
      if (i == 4) check("full_after_4", fifo_full, 1);
    end
    check("ovf_after_5", ovf, 1);
    drain();
    clear_errs();

    send(mk(8'h21, 8'h01));
    send(mk(8'h21, 8'h02));
    f = mk(8'h21, 8'h03);
    model_frame(f, push);
    dec_command = f;
    dec_ready = 1;
    repeat (2) @(negedge clk);
    check("pp_head_before", key_data, 16'h2101);
    void'(exp_q.pop_front());
    dir_pop = 1;
    @(negedge clk);
    dir_pop = 0;
    check("pp_ack", dec_ack, 1);
    check("pp_head_after", key_data, 16'h2102);
    dec_ready = 0;
    @(negedge clk);
    send(mk(8'h21, 8'h04));
    check("pp_not_full_3", fifo_full, 0);
    send(mk(8'h21, 8'h05));
    check("pp_full_4", fifo_full, 1);
    drain();

    send(mk(8'h33, 8'h44));
    t = cyc;
    send(32'hF708FB04);
    repeat (40) @(negedge clk);
    send(32'hF708FB04);
    check("repeat_count", exp_q.size(), FILT ? 2 : 3);
    while (cyc < t + 160) @(negedge clk);
    send(32'hF708FB04);
    drain();

    sw_enable = 0;
    repeat (2) @(negedge clk);
    check("dec_enable_off", dec_enable, 0);
    dec_command = mk(8'h77, 8'h66);
    dec_ready = 1;
    repeat (10) @(negedge clk);
    check("disabled_no_ack", dec_ack, 0);
    check("disabled_no_key", key_valid, 0);
    dec_ready = 0;
    sw_enable = 1;
    repeat (2) @(negedge clk);

    mode = 1;
    repeat (60) begin
      n = 0;
      while (exp_q.size() >= DEPTH && n < 200) begin
        @(negedge clk);
        n++;
      end
      if ($urandom_range(3) != 0) begin
        do k = 16'($urandom); while (!none && k == last_key);
        f = mk(k[15:8], k[7:0]);
      end else f = mk(8'($urandom), 8'($urandom)) ^ (32'd1 << $urandom_range(31));
      send(f);
    end
    drain();

    send(mk(8'h41, 8'h01));
    send(mk(8'h41, 8'h02));
    dec_command = mk(8'h41, 8'h03);
    dec_ready = 1;
    n = 0;
    while (!dec_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_in_ack", dec_ack, 1);
    rst = 1;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    err_exp = 0;
    ovf_exp = 0;
    none = 1;
    @(negedge clk);
    f = mk(8'h5A, 8'h3C);
    dec_command = f;
    rst = 0;
    model_frame(f, push);
    n = 0;
    while (!dec_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_ack", dec_ack, 1);
    check("post_rst_key", key_data, 16'h5A3C);
    dec_ready = 0;
    @(negedge clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
